// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins plus the RAM-side word handshake.
// slave modport is the block, master modport is the driver (SPI master + RAM).
interface spi_slave_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
);
  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave to single-port RAM bridge: command/payload in, read data out.
// Define SPI_SLAVE_SVA_EN to compile the embedded protocol assertions.
module spi_slave #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_slave_if.slave bus
);

  localparam int CW  = $clog2(RX_WIDTH + 1);
  localparam int TCW = $clog2(TX_WIDTH + 1);
  localparam logic [CW-1:0]  RX_LAST = CW'(RX_WIDTH);
  localparam logic [TCW-1:0] TX_LAST = TCW'(TX_WIDTH);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_bit_cnt;
  logic [RX_WIDTH-1:0] r_shift;
  logic [RX_WIDTH-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_done;
  logic                r_rd_flag;
  logic                r_wait_tx;
  logic                r_tx_act;
  logic [TX_WIDTH-1:0] r_tx_shift;
  logic [TCW-1:0]      r_tx_cnt;
  logic                r_miso;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rd_flag  <= 1'b0;
      r_wait_tx  <= 1'b0;
      r_tx_act   <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          if (!bus.SS_n)
            r_state <= CHK_CMD;
        end
        CHK_CMD: begin
          if (bus.SS_n)
            r_state <= IDLE;
          else if (!bus.MOSI)
            r_state <= WRITE;
          else if (r_rd_flag)
            r_state <= READ_DATA;
          else
            r_state <= READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bus.SS_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_wait_tx  <= 1'b0;
            r_tx_act   <= 1'b0;
            r_tx_cnt   <= '0;
            r_miso     <= 1'b0;
          end else if (!r_done) begin
            if (r_bit_cnt != RX_LAST) begin
              r_shift   <= {r_shift[RX_WIDTH-2:0], bus.MOSI};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_done     <= 1'b1;
              if (r_state == READ_ADD)
                r_rd_flag <= 1'b1;
              if (r_state == READ_DATA)
                r_wait_tx <= 1'b1;
            end
          end else if (r_wait_tx) begin
            if (bus.tx_valid) begin
              r_tx_shift <= bus.tx_data;
              r_tx_cnt   <= TX_LAST;
              r_wait_tx  <= 1'b0;
              r_tx_act   <= 1'b1;
            end
          end else if (r_tx_act) begin
            if (r_tx_cnt != '0) begin
              r_miso     <= r_tx_shift[TX_WIDTH-1];
              r_tx_shift <= {r_tx_shift[TX_WIDTH-2:0], 1'b0};
              r_tx_cnt   <= r_tx_cnt - 1'b1;
            end else begin
              // Read word fully shifted out: next read is an address again
              r_miso    <= 1'b0;
              r_tx_act  <= 1'b0;
              r_rd_flag <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MISO     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_SVA_EN
  logic [7:0] r_ss_lo;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ss_lo <= '0;
    else if (bus.SS_n)
      r_ss_lo <= '0;
    else if (r_ss_lo != 8'hFF)
      r_ss_lo <= r_ss_lo + 1'b1;
  end

  a_rxv_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    r_rx_valid |=> !r_rx_valid);

  a_rxv_sel: assert property (@(posedge clk) disable iff (!rst_n)
    r_rx_valid |-> !$past(bus.SS_n));

  a_idle_miso: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == IDLE) |-> !r_miso);

  a_rxv_lat: assert property (@(posedge clk) disable iff (!rst_n)
    r_rx_valid |-> (r_ss_lo >= 8'(RX_WIDTH + 2)));
`endif

endmodule
